// File: rtl/csr_pkg.sv
// Shared constants for the Zicsr unit: CSR address map, funct3 op encodings,
// fcsr field positions and the FSM state type.
package csr_pkg;

  localparam logic [11:0] CSR_FFLAGS    = 12'h001;
  localparam logic [11:0] CSR_FRM       = 12'h002;
  localparam logic [11:0] CSR_FCSR      = 12'h003;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;

  // fflags occupies fcsr[4:0] (NV,DZ,OF,UF,NX from bit 4 down), frm fcsr[7:5]
  localparam int FFLAGS_LSB = 0;
  localparam int FFLAGS_MSB = 4;
  localparam int FRM_LSB    = 5;
  localparam int FRM_MSB    = 7;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } csrState_t;

  function automatic logic isCounterAddr(input logic [11:0] addr);
    return addr inside {CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
                        CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH};
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and 32-bit half writes; a half write
// replaces that half of the incremented value, so it always wins.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_wrLo,
  input  logic        i_wrHi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_value
);

  logic [63:0] r_count;
  logic [63:0] w_next;

  always_comb begin
    w_next = r_count + {63'd0, i_inc};
    if (i_wrLo) w_next[31:0]  = i_wdata;
    if (i_wrHi) w_next[63:32] = i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= w_next;
  end

  assign o_value = r_count;

endmodule

// File: rtl/csr_unit.sv
// Zicsr CSR unit: fcsr/fflags/frm, mscratch and, when CSR_COUNTERS_EN is
// defined, the 64-bit mcycle/minstret counters with their read-only aliases.
module csr_unit
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid_i,
  output logic        csr_ready_o,
  input  logic [2:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        csr_src_zero_i,
  output logic        csr_done_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instret_i,
  input  logic        fflags_we_i,
  input  logic [4:0]  fflags_i,
  output logic [2:0]  frm_o
);

  csrState_t r_state;
  csrState_t w_stateNext;

  logic [4:0]  r_fflags;
  logic [2:0]  r_frm;
  logic [31:0] r_mscratch;
  logic [31:0] r_rdata;
  logic        r_illegal;

  logic [63:0] w_cycleVal;
  logic [63:0] w_instretVal;
  logic [31:0] w_oldVal;
  logic [31:0] w_newVal;
  logic [4:0]  w_accrue;
  logic        w_known;
  logic        w_mapped;
  logic        w_opOk;
  logic        w_we;
  logic        w_illegal;
  logic        w_accept;
  logic        w_commit;

`ifdef CSR_COUNTERS_EN
  localparam logic COUNTERS_ON = 1'b1;

  csr_counter64 u_cycle (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (1'b1),
    .i_wrLo  (w_commit && (csr_addr_i == CSR_MCYCLE)),
    .i_wrHi  (w_commit && (csr_addr_i == CSR_MCYCLEH)),
    .i_wdata (w_newVal),
    .o_value (w_cycleVal)
  );

  csr_counter64 u_instret (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (instret_i),
    .i_wrLo  (w_commit && (csr_addr_i == CSR_MINSTRET)),
    .i_wrHi  (w_commit && (csr_addr_i == CSR_MINSTRETH)),
    .i_wdata (w_newVal),
    .o_value (w_instretVal)
  );
`else
  localparam logic COUNTERS_ON = 1'b0;
  logic w_unusedInstret;

  assign w_cycleVal      = '0;
  assign w_instretVal    = '0;
  assign w_unusedInstret = instret_i;
`endif

  // Old-value read mux; counter addresses only count as mapped when built
  always_comb begin
    w_oldVal = '0;
    w_known  = 1'b1;
    case (csr_addr_i)
      CSR_FFLAGS:                 w_oldVal = {27'd0, r_fflags};
      CSR_FRM:                    w_oldVal = {29'd0, r_frm};
      CSR_FCSR:                   w_oldVal = {24'd0, r_frm, r_fflags};
      CSR_MSCRATCH:               w_oldVal = r_mscratch;
      CSR_MCYCLE, CSR_CYCLE:      w_oldVal = w_cycleVal[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:    w_oldVal = w_cycleVal[63:32];
      CSR_MINSTRET, CSR_INSTRET:  w_oldVal = w_instretVal[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_oldVal = w_instretVal[63:32];
      default:                    w_known  = 1'b0;
    endcase
  end

  assign w_mapped = w_known && (COUNTERS_ON || !isCounterAddr(csr_addr_i));

  always_comb begin
    w_newVal = csr_wdata_i;
    w_we     = 1'b0;
    w_opOk   = 1'b1;
    case (csr_op_i)
      OP_RW, OP_RWI: begin
        w_newVal = csr_wdata_i;
        w_we     = 1'b1;
      end
      OP_RS, OP_RSI: begin
        w_newVal = w_oldVal | csr_wdata_i;
        w_we     = !csr_src_zero_i;
      end
      OP_RC, OP_RCI: begin
        w_newVal = w_oldVal & ~csr_wdata_i;
        w_we     = !csr_src_zero_i;
      end
      default: w_opOk = 1'b0;
    endcase
  end

  assign w_illegal = !w_mapped || !w_opOk || (w_we && (csr_addr_i[11:10] == 2'b11));
  assign w_accept  = csr_valid_i && csr_ready_o;
  assign w_commit  = w_accept && w_we && !w_illegal;
  assign w_accrue  = fflags_we_i ? fflags_i : 5'd0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_stateNext = ST_RESP;
      ST_RESP: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_ready_o = (r_state == ST_IDLE);
    csr_done_o  = (r_state == ST_RESP);
  end

  // FPU accrual is OR-ed on top of any software write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fflags   <= '0;
      r_frm      <= '0;
      r_mscratch <= '0;
      r_rdata    <= '0;
      r_illegal  <= 1'b0;
    end else begin
      if (w_commit && (csr_addr_i == CSR_FFLAGS))
        r_fflags <= w_newVal[FFLAGS_MSB:FFLAGS_LSB] | w_accrue;
      else if (w_commit && (csr_addr_i == CSR_FCSR))
        r_fflags <= w_newVal[FFLAGS_MSB:FFLAGS_LSB] | w_accrue;
      else
        r_fflags <= r_fflags | w_accrue;

      if (w_commit && (csr_addr_i == CSR_FRM))  r_frm <= w_newVal[2:0];
      if (w_commit && (csr_addr_i == CSR_FCSR)) r_frm <= w_newVal[FRM_MSB:FRM_LSB];

      if (w_commit && (csr_addr_i == CSR_MSCRATCH)) r_mscratch <= w_newVal;

      if (w_accept) begin
        r_rdata   <= w_illegal ? 32'd0 : w_oldVal;
        r_illegal <= w_illegal;
      end
    end
  end

  assign csr_rdata_o   = r_rdata;
  assign csr_illegal_o = r_illegal;
  assign frm_o         = r_frm;

endmodule

// File: doc/csr_unit.md
# csr_unit

Zicsr control/status register unit for the RV32IMF core. It is the block the core's CSR instruction path hands decoded CSRRW/CSRRS/CSRRC (and immediate-form) requests to, and it returns the old CSR value for write-back to rd. It owns fcsr (fflags/frm), mscratch and the 64-bit cycle/instret counters. It also accrues FPU exception flags and drives the rounding mode to the FPU.

## Interface
- Parameters: none; address map and op encodings come from `csr_pkg`.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `csr_valid_i`  in  1  request valid.
- `csr_ready_o`  out  1  unit can accept a request; high only in IDLE.
- `csr_op_i`  in  3  instruction funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 are illegal.
- `csr_addr_i`  in  12  CSR address.
- `csr_wdata_i`  in  32  rs1 value, or zimm zero-extended to 32 bits.
- `csr_src_zero_i`  in  1  rs1 index / zimm is 0; suppresses the write for RS/RC forms.
- `csr_done_o`  out  1  one-cycle response strobe.
- `csr_rdata_o`  out  32  old CSR value; valid while done.
- `csr_illegal_o`  out  1  illegal access; valid while done.
- `instret_i`  in  1  one-cycle pulse per retired instruction.
- `fflags_we_i`  in  1  FPU flag accrual strobe.
- `fflags_i`  in  5  FPU flags NV,DZ,OF,UF,NX (bits 4..0).
- `frm_o`  out  3  current rounding mode to the FPU.

## Operation
- Address map:
  - fflags 0x001 (RW)
  - frm 0x002 (RW)
  - fcsr 0x003 (RW, bits [7:0], upper bits read 0)
  - mscratch 0x340 (RW)
  - mcycle/mcycleh 0xB00/0xB80 (RW)
  - minstret/minstreth 0xB02/0xB82 (RW)
  - cycle/cycleh 0xC00/0xC80 (RO)
  - instret/instreth 0xC02/0xC82 (RO)
- New value by op:
  - RW: `wdata`.
  - RS: `old | wdata`.
  - RC: `old & ~wdata`.
- Write enable: RW forms always write. RS/RC forms write only when `csr_src_zero_i` is 0.
- Illegal when any of the following holds. An illegal access changes no state and returns `rdata` 0 with `illegal_o` 1.
  - unmapped address;
  - op 000 or 100;
  - write enable set and `addr[11:10]==2'b11`.
- A legal RS/RC with a zero source to a read-only CSR is not illegal.
- mcycle increments every cycle. minstret increments on `instret_i`. Both are 64-bit and wrap from 2^64-1 to 0.
- A write to the low or high half replaces only that 32-bit half. It takes precedence over the increment in that cycle, so there is no carry into the written half.
- FPU accrual: fflags <= fflags | `fflags_i` when `fflags_we_i`. If a software write to fflags/fcsr occurs in the same cycle, the result is software value | `fflags_i`; the accrual is never lost.
- `frm_o` is combinational from the frm register. Reserved frm values 5..7 are stored as written.

## Timing
- FSM states and transitions:
  - IDLE -> RESP on `csr_valid_i && csr_ready_o` (accept edge E0).
  - RESP -> IDLE unconditionally at the next edge.
  - Back-to-back requests are accepted every 2 cycles.
- At E0:
  - the old value is sampled (pre-increment counter value) into `csr_rdata_o`;
  - the write is committed;
  - `csr_illegal_o` is registered.
- `csr_done_o` is 1 during RESP only. Latency from accept to done is 1 cycle.
- `csr_valid_i` while in RESP is ignored; the requester must hold it until ready.
- Reset values: state IDLE, `csr_ready_o` 1, `csr_done_o` 0, `csr_rdata_o` 0, `csr_illegal_o` 0, `frm_o` 0. fflags, mscratch and both counters reset to 0.
- Reset asserted in RESP: the response is dropped and `done` is 0 the next cycle. The E0 write is overwritten by the reset values.

## Configuration
- `CSR_COUNTERS_EN` defined: mcycle/minstret and their cycle/instret aliases are implemented.
- Undefined: the counter registers are not built, all eight counter addresses are illegal, and `instret_i` is unused.

## Structure
- `csr_pkg`: 12-bit address localparams, funct3 op encodings, fflags bit positions.
- Sub-module `csr_counter64`: 64-bit register with increment enable, `wr_lo`/`wr_hi` half-word writes (write beats increment), and a 64-bit read-out. Instantiated twice (cycle, instret).

## Test plan
- Reset, then CSRRW 0x340 with `wdata`=0xDEADBEEF -> done after 1 cycle, `rdata` 0. A following CSRRS 0x340 with zero source -> `rdata` 0xDEADBEEF, no write.
- CSRRC 0x340 with `wdata`=0x0000FFFF -> `rdata` 0xDEADBEEF; a subsequent read gives 0xDEAD0000.
- CSRRWI 0xC00 with zimm=5 -> `illegal_o` 1, `rdata` 0, cycle unchanged. CSRRS 0xC00 with zero source -> legal, `rdata` equals the cycle count at accept.
- Write mcycle=0xFFFFFFFF and mcycleh=0xFFFFFFFF, wait -> the count wraps to 0 and mcycleh reads 0 afterwards. An `instret_i` pulse in the same cycle as a minstret write of 7 -> reads 7.
- Write frm with 3'b010 -> `frm_o`=2. Write fflags 0x01 in the same cycle as `fflags_we_i` with `fflags_i`=0x10 -> fcsr reads 0x51.
- Request accepted, reset asserted in RESP -> `done` 0 next cycle, mscratch 0, `csr_ready_o` 1.
